// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and pipeline-sequencing controller for a 5-stage RISC-V pipeline.
//   Produces stall/flush controls for the F/D/E/M/W pipeline registers,
//   operand forwarding selects for Execute, a memory-wait FSM with timeout,
//   and saturating stall/flush event counters.
//
// Parameters
//   CNT_W    width of each performance counter
//   TIMEOUT  number of frozen cycles allowed per data access before the
//            access is abandoned and mem_err is raised (1..65535)
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   rs1D/rs2D                       source registers in Decode
//   rs1E/rs2E, rdE                  source / destination registers in Execute
//   rdM, rdW                        destination registers in Memory / Writeback
//   regwriteE/M/W                   register-write enables per stage
//   wbselE                          writeback select in Execute (00 = load)
//   pcselE                          taken branch / jump resolved in Execute
//   memreqM, dmem_ready             data access in Memory and its completion
//   stallF/D/E/M                    hold PC and pipeline registers
//   flushD/E/W                      clear F/D, D/E, bubble into M/W
//   forwardAE/BE                    00 regfile, 01 resultW, 10 ALU result in M
//   mem_err                         sticky memory-timeout flag
//   stall_cnt, flush_cnt            saturating event counters
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic [1:0]       wbselE,
  input  logic             pcselE,
  input  logic             memreqM,
  input  logic             dmem_ready,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [15:0]      wait_q, wait_d, wait_cur;
  logic             mem_err_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic             lu;
  logic             mem_stall;
  logic             timeout_hit;

  // ---------------------------------------------------------------------------
  // Forwarding: M has priority over W; x0 never forwards.
  // ---------------------------------------------------------------------------
  logic [4:0] rs_e [2];
  logic [1:0] fwd  [2];

  assign rs_e[0] = rs1E;
  assign rs_e[1] = rs2E;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd[gi] = (regwriteM && (rdM != 5'd0) && (rdM == rs_e[gi])) ? 2'b10 :
                     (regwriteW && (rdW != 5'd0) && (rdW == rs_e[gi])) ? 2'b01 :
                                                                          2'b00;
  end

  assign forwardAE = fwd[0];
  assign forwardBE = fwd[1];

  // ---------------------------------------------------------------------------
  // Hazard detection and next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    lu = regwriteE && (wbselE == 2'b00) && (rdE != 5'd0) &&
         ((rdE == rs1D) || (rdE == rs2D));

    // The freeze starts combinationally in the cycle the access first misses,
    // and ends in the same cycle dmem_ready arrives.
    mem_stall = !dmem_ready &&
                ((state_q == MEM_WAIT) || ((state_q == RUN) && memreqM));

    // The first frozen cycle (still in RUN) is wait index 0; wait_q holds the
    // number of frozen cycles already spent while in MEM_WAIT. With this the
    // pipe is frozen for exactly TIMEOUT cycles before ERR.
    wait_cur    = (state_q == RUN) ? 16'd0 : wait_q;
    timeout_hit = mem_stall && (wait_cur == WAIT_LAST);

    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN: begin
        wait_d = 16'd0;
        if (mem_stall) begin
          state_d = timeout_hit ? ERR : MEM_WAIT;
          wait_d  = timeout_hit ? 16'd0 : 16'd1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
          wait_d  = 16'd0;
        end else if (timeout_hit) begin
          state_d = ERR;
          wait_d  = 16'd0;
        end else begin
          wait_d  = wait_q + 16'd1;
        end
      end
      ERR: begin
        state_d = RUN;
        wait_d  = 16'd0;
      end
      default: begin
        state_d = RUN;
        wait_d  = 16'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stall / flush controls. Held low while reset is asserted so the pipe sees
  // no controls even if a memory request is still being presented.
  // ---------------------------------------------------------------------------
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (rst_n) begin
      if (mem_stall) begin
        // Whole pipe frozen; redirects and load-use wait until it moves.
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (state_q == ERR) begin
        // Abandoned access: keep its (missing) result out of writeback.
        flushW = 1'b1;
      end else if (pcselE) begin
        // Redirect wins: the load-use consumer in Decode is flushed anyway.
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (lu) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State, sticky error flag and saturating counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_q      <= 16'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_d == ERR) begin
        mem_err_q <= 1'b1;
      end
      if (stallF && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flushE && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       regwriteE, regwriteM, regwriteW;
  logic [1:0] wbselE;
  logic       pcselE, memreqM, dmem_ready;

  // Instance A: default parameters. Instance B: TIMEOUT=4, CNT_W=4.
  logic        stallF_a, stallD_a, stallE_a, stallM_a, flushD_a, flushE_a, flushW_a;
  logic [1:0]  fwdA_a, fwdB_a;
  logic        mem_err_a;
  logic [31:0] scnt_a, fcnt_a;
  logic        stallF_b, stallD_b, stallE_b, stallM_b, flushD_b, flushE_b, flushW_b;
  logic [1:0]  fwdA_b, fwdB_b;
  logic        mem_err_b;
  logic [3:0]  scnt_b, fcnt_b;

  logic [6:0] ctl_a, ctl_b;
  assign ctl_a = {stallF_a, stallD_a, stallE_a, stallM_a, flushD_a, flushE_a, flushW_a};
  assign ctl_b = {stallF_b, stallD_b, stallE_b, stallM_b, flushD_b, flushE_b, flushW_b};

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(32), .TIMEOUT(255)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .wbselE(wbselE), .pcselE(pcselE), .memreqM(memreqM), .dmem_ready(dmem_ready),
    .stallF(stallF_a), .stallD(stallD_a), .stallE(stallE_a), .stallM(stallM_a),
    .flushD(flushD_a), .flushE(flushE_a), .flushW(flushW_a),
    .forwardAE(fwdA_a), .forwardBE(fwdB_a),
    .mem_err(mem_err_a), .stall_cnt(scnt_a), .flush_cnt(fcnt_a)
  );

  hazard_ctrl #(.CNT_W(4), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .wbselE(wbselE), .pcselE(pcselE), .memreqM(memreqM), .dmem_ready(dmem_ready),
    .stallF(stallF_b), .stallD(stallD_b), .stallE(stallE_b), .stallM(stallM_b),
    .flushD(flushD_b), .flushE(flushE_b), .flushW(flushW_b),
    .forwardAE(fwdA_b), .forwardBE(fwdB_b),
    .mem_err(mem_err_b), .stall_cnt(scnt_b), .flush_cnt(fcnt_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------------------------------------------------------------------
  // Reference model: per instance, how many frozen cycles the current access
  // has used, whether this cycle is the abandon cycle, and event totals.
  // ---------------------------------------------------------------------------
  typedef struct {
    int     frozen_used;
    bit     abandon;
    bit     err;
    longint scnt;
    longint fcnt;
  } mst_t;

  mst_t   m [2];
  int     tmo  [2] = '{255, 4};
  longint cmax [2] = '{64'hFFFF_FFFF, 64'd15};

  function automatic bit model_lu();
    return regwriteE && wbselE == 2'b00 && rdE != 0 && (rdE == rs1D || rdE == rs2D);
  endfunction

  function automatic bit model_frozen(int i);
    return rst_n && !m[i].abandon && !dmem_ready && (m[i].frozen_used > 0 || memreqM);
  endfunction

  // {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
  function automatic logic [6:0] exp_ctl(int i);
    if (!rst_n)                return 7'b0000_000;
    if (model_frozen(i))       return 7'b1111_001;
    if (m[i].abandon)          return 7'b0000_001;
    if (pcselE)                return 7'b0000_110;
    if (model_lu())            return 7'b1100_010;
    return 7'b0000_000;
  endfunction

  function automatic logic [1:0] exp_fwd(logic [4:0] rs);
    if (regwriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (regwriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic void model_advance();
    for (int i = 0; i < 2; i++) begin
      logic [6:0] c;
      bit fr;
      c  = exp_ctl(i);
      fr = model_frozen(i);
      if (c[6] && m[i].scnt < cmax[i]) m[i].scnt++;
      if (c[1] && m[i].fcnt < cmax[i]) m[i].fcnt++;
      if (fr) begin
        if (m[i].frozen_used == tmo[i] - 1) begin
          m[i].abandon     = 1'b1;
          m[i].err         = 1'b1;
          m[i].frozen_used = 0;
        end else begin
          m[i].frozen_used++;
          m[i].abandon = 1'b0;
        end
      end else begin
        m[i].frozen_used = 0;
        m[i].abandon     = 1'b0;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].frozen_used = 0;
      m[i].abandon     = 1'b0;
      m[i].err         = 1'b0;
      m[i].scnt        = 0;
      m[i].fcnt        = 0;
    end
  endfunction

  task automatic clear_inputs();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0; wbselE = 2'b01;
    pcselE = 0; memreqM = 0; dmem_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    rs1E = 5; rdM = 5; regwriteM = 1; memreqM = 1; dmem_ready = 0;
    rdE = 3; rs1D = 3; regwriteE = 1; wbselE = 2'b00;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (ctl_a !== 7'b0 || ctl_b !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_ctl: got a=%b b=%b expected 0000000", ctl_a, ctl_b);
    end
    n_cmp++;
    if (scnt_a !== 0 || fcnt_a !== 0 || mem_err_a !== 1'b0 || mem_err_b !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got scnt=%0d fcnt=%0d err=%b/%b expected 0 0 0/0",
               scnt_a, fcnt_a, mem_err_a, mem_err_b);
    end
    n_cmp++;
    if (fwdA_a !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_fwd: got %b expected 10", fwdA_a);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_forwarding();
    do_reset();
    rs1E = 5; rdM = 5; regwriteM = 1; rdW = 5; regwriteW = 1;
    #1;
    n_cmp++;
    if (fwdA_a !== 2'b10) begin
      n_bad++; $display("FAIL fwd_M_prio: got %b expected 10", fwdA_a);
    end
    regwriteM = 0;
    #1;
    n_cmp++;
    if (fwdA_a !== 2'b01) begin
      n_bad++; $display("FAIL fwd_W: got %b expected 01", fwdA_a);
    end
    regwriteM = 1; rdM = 0; rdW = 0; rs1E = 0; rs2E = 0;
    #1;
    n_cmp++;
    if (fwdA_a !== 2'b00 || fwdB_a !== 2'b00) begin
      n_bad++; $display("FAIL fwd_x0: got A=%b B=%b expected 00 00", fwdA_a, fwdB_a);
    end
    rs2E = 9; rdW = 9; rdM = 4;
    #1;
    n_cmp++;
    if (fwdB_a !== 2'b01 || fwdA_a !== 2'b00) begin
      n_bad++; $display("FAIL fwd_B: got A=%b B=%b expected 00 01", fwdA_a, fwdB_a);
    end
    $display("test_forwarding done");
  endtask

  task automatic test_load_use();
    do_reset();
    regwriteE = 1; wbselE = 2'b00; rdE = 7; rs2D = 7;
    #1;
    n_cmp++;
    if (ctl_a !== 7'b1100_010) begin
      n_bad++; $display("FAIL load_use_ctl: got %b expected 1100010", ctl_a);
    end
    tick();
    regwriteE = 0;
    #1;
    n_cmp++;
    if (scnt_a !== 32'd1 || fcnt_a !== 32'd1 || ctl_a !== 7'b0) begin
      n_bad++;
      $display("FAIL load_use_cnt: got scnt=%0d fcnt=%0d ctl=%b expected 1 1 0000000",
               scnt_a, fcnt_a, ctl_a);
    end
    regwriteE = 1; rdE = 0; rs1D = 0; rs2D = 0;
    #1;
    n_cmp++;
    if (ctl_a !== 7'b0) begin
      n_bad++; $display("FAIL load_use_x0: got %b expected 0000000", ctl_a);
    end
    $display("test_load_use done");
  endtask

  task automatic test_redirect();
    do_reset();
    regwriteE = 1; wbselE = 2'b00; rdE = 7; rs2D = 7; pcselE = 1;
    #1;
    n_cmp++;
    if (ctl_a !== 7'b0000_110) begin
      n_bad++; $display("FAIL redirect_ctl: got %b expected 0000110", ctl_a);
    end
    tick();
    pcselE = 0; regwriteE = 0;
    n_cmp++;
    if (scnt_a !== 32'd0 || fcnt_a !== 32'd1) begin
      n_bad++; $display("FAIL redirect_cnt: got scnt=%0d fcnt=%0d expected 0 1", scnt_a, fcnt_a);
    end
    $display("test_redirect done");
  endtask

  task automatic test_mem_wait();
    do_reset();
    memreqM = 1; dmem_ready = 0;
    pcselE = 1;  // must be ignored while frozen
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (ctl_a !== 7'b1111_001) begin
        n_bad++; $display("FAIL mem_wait_cyc%0d: got %b expected 1111001", k, ctl_a);
      end
      tick();
    end
    pcselE = 0;
    dmem_ready = 1;
    #1;
    n_cmp++;
    if (ctl_a !== 7'b0) begin
      n_bad++; $display("FAIL mem_release: got %b expected 0000000", ctl_a);
    end
    tick();
    memreqM = 0;
    n_cmp++;
    if (scnt_a !== 32'd3 || mem_err_a !== 1'b0) begin
      n_bad++; $display("FAIL mem_wait_cnt: got scnt=%0d err=%b expected 3 0", scnt_a, mem_err_a);
    end
    $display("test_mem_wait done");
  endtask

  task automatic test_timeout();
    do_reset();
    memreqM = 1; dmem_ready = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if (ctl_b !== 7'b1111_001) begin
        n_bad++; $display("FAIL timeout_stall%0d: got %b expected 1111001", k, ctl_b);
      end
      tick();
    end
    #1;
    n_cmp++;
    if (ctl_b !== 7'b0000_001 || mem_err_b !== 1'b1) begin
      n_bad++; $display("FAIL timeout_err: got ctl=%b err=%b expected 0000001 1", ctl_b, mem_err_b);
    end
    tick();
    memreqM = 0;
    #1;
    n_cmp++;
    if (ctl_b !== 7'b0 || mem_err_b !== 1'b1 || scnt_b !== 4'd4) begin
      n_bad++;
      $display("FAIL timeout_sticky: got ctl=%b err=%b scnt=%0d expected 0000000 1 4",
               ctl_b, mem_err_b, scnt_b);
    end
    tick();
    // Reset in the middle of a wait
    memreqM = 1; dmem_ready = 0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (ctl_a !== 7'b0 || ctl_b !== 7'b0 || mem_err_b !== 1'b0 || scnt_b !== 4'd0 ||
        scnt_a !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_mid_wait: got a=%b b=%b err=%b scnt=%0d/%0d expected all 0",
               ctl_a, ctl_b, mem_err_b, scnt_a, scnt_b);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    $display("test_timeout done");
  endtask

  task automatic test_saturation();
    do_reset();
    regwriteE = 1; wbselE = 2'b00; rdE = 12; rs1D = 12;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_cmp++;
      if (longint'(scnt_b) != m[1].scnt || fcnt_b !== 4'(m[1].fcnt)) begin
        n_bad++;
        $display("FAIL sat_step%0d: got scnt=%0d fcnt=%0d expected %0d %0d",
                 k, scnt_b, fcnt_b, m[1].scnt, m[1].fcnt);
      end
    end
    n_cmp++;
    if (scnt_b !== 4'd15 || scnt_a !== 32'd20) begin
      n_bad++; $display("FAIL sat_final: got b=%0d a=%0d expected 15 20", scnt_b, scnt_a);
    end
    clear_inputs();
    $display("test_saturation done");
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
      rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
      rdE  = 5'($urandom_range(0, 3)); rdM  = 5'($urandom_range(0, 3));
      rdW  = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
      wbselE     = 2'($urandom_range(0, 3));
      pcselE     = ($urandom_range(0, 7) == 0);
      memreqM    = ($urandom_range(0, 3) == 0);
      dmem_ready = ($urandom_range(0, 9) < 5);
      #1;
      n_cmp++;
      if (ctl_a !== exp_ctl(0) || ctl_b !== exp_ctl(1)) begin
        n_bad++;
        $display("FAIL rand_ctl%0d: got a=%b b=%b expected a=%b b=%b",
                 k, ctl_a, ctl_b, exp_ctl(0), exp_ctl(1));
      end
      n_cmp++;
      if (fwdA_a !== exp_fwd(rs1E) || fwdB_a !== exp_fwd(rs2E) ||
          fwdA_b !== exp_fwd(rs1E) || fwdB_b !== exp_fwd(rs2E)) begin
        n_bad++;
        $display("FAIL rand_fwd%0d: got A=%b B=%b expected A=%b B=%b",
                 k, fwdA_a, fwdB_a, exp_fwd(rs1E), exp_fwd(rs2E));
      end
      tick();
      n_cmp++;
      if (longint'(scnt_a) != m[0].scnt || longint'(fcnt_a) != m[0].fcnt ||
          longint'(scnt_b) != m[1].scnt || longint'(fcnt_b) != m[1].fcnt ||
          mem_err_a !== m[0].err || mem_err_b !== m[1].err) begin
        n_bad++;
        $display("FAIL rand_state%0d: got s=%0d/%0d f=%0d/%0d e=%b/%b expected s=%0d/%0d f=%0d/%0d e=%b/%b",
                 k, scnt_a, scnt_b, fcnt_a, fcnt_b, mem_err_a, mem_err_b,
                 m[0].scnt, m[1].scnt, m[0].fcnt, m[1].fcnt, m[0].err, m[1].err);
      end
    end
    clear_inputs();
    $display("test_random done");
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
